// File: rtl/result_requant_if.sv
// Result-stream bundle: 64-bit accumulator beats in, packed int8 rows out, plus frame status.
interface result_requant_if;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  shift_amt;
    logic [31:0] out_data;
    logic [1:0]  out_row;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        frame_done;
    logic [4:0]  sat_count;

    // Producer/consumer side (drives beats and row acceptance).
    modport master (
        output in_data, in_valid, shift_amt, out_ready,
        input  in_ready, out_data, out_row, out_valid, out_last, frame_done, sat_count
    );

    // Requantizer side.
    modport slave (
        input  in_data, in_valid, shift_amt, out_ready,
        output in_ready, out_data, out_row, out_valid, out_last, frame_done, sat_count
    );
endinterface

// File: rtl/result_requant.sv
// Requantizes a 4x4 matrix of signed 32-bit accumulators to int8 (rounding right shift with
// saturation) and re-emits it row by row as packed 32-bit words.
module result_requant #(
    parameter int unsigned NUM_BEATS = 8,
    parameter int unsigned ACC_W     = 32,
    parameter int unsigned OUT_W     = 8
) (
    input logic             i_clk,
    input logic             i_reset,
    result_requant_if.slave io_bus
);
    localparam int unsigned NumElem = 2 * NUM_BEATS;
    localparam int unsigned NumRows = 4;
    localparam int unsigned NumCols = NumElem / NumRows;
    localparam int unsigned CntW    = $clog2(NUM_BEATS);
    localparam logic [CntW-1:0] LastBeat = CntW'(NUM_BEATS - 1);
    localparam logic signed [ACC_W:0] QMax = (ACC_W + 1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W:0] QMin = ~QMax;

    typedef enum logic [1:0] {StCollect, StRequant, StEmit} state_e;

    state_e                  r_state;
    state_e                  w_state_d;
    logic [CntW-1:0]         r_cnt;
    logic [4:0]              r_shift;
    logic [ACC_W-1:0]        r_elem [NumElem];
    logic [1:0]              r_req;
    logic [4:0]              r_sat_acc;
    logic [4:0]              r_sat_count;
    logic [NumCols*OUT_W-1:0] r_row_buf [NumRows];
    logic [1:0]              r_out_row;

    logic                    w_in_hs;
    logic                    w_out_hs;
    logic [NumCols*OUT_W-1:0] w_row;
    logic [2:0]              w_row_sat;

    // Returns {saturated, int8}. The 33-bit intermediate keeps the rounding add from wrapping.
    function automatic logic [OUT_W:0] requant(input logic [ACC_W-1:0] x, input logic [4:0] sh);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] rnd;
        logic signed [ACC_W:0] v;
        logic [OUT_W:0]        res;
        ext = $signed({x[ACC_W-1], x});
        rnd = '0;
        if (sh == 5'd0) begin
            v = ext;
        end else begin
            rnd = $signed((ACC_W + 1)'(1) << (sh - 5'd1));
            v   = (ext + rnd) >>> sh;
        end
        if (v > QMax) begin
            res = {1'b1, QMax[OUT_W-1:0]};
        end else if (v < QMin) begin
            res = {1'b1, QMin[OUT_W-1:0]};
        end else begin
            res = {1'b0, v[OUT_W-1:0]};
        end
        return res;
    endfunction

    assign w_in_hs  = io_bus.in_valid && (r_state == StCollect);
    assign w_out_hs = io_bus.out_ready && (r_state == StEmit);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= StCollect;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Next-state: collect 8 beats, spend one cycle per row requantizing, then drain 4 rows.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StCollect: if (w_in_hs && (r_cnt == LastBeat)) w_state_d = StRequant;
            StRequant: if (r_req == 2'd3) w_state_d = StEmit;
            StEmit:    if (w_out_hs && (r_out_row == 2'd3)) w_state_d = StCollect;
            default:   w_state_d = StCollect;
        endcase
    end

    // Outputs are pure functions of registered state; frame_done marks the row-3 handshake.
    always_comb begin
        io_bus.in_ready   = (r_state == StCollect);
        io_bus.out_valid  = (r_state == StEmit);
        io_bus.out_data   = (r_state == StEmit) ? r_row_buf[r_out_row] : '0;
        io_bus.out_row    = r_out_row;
        io_bus.out_last   = (r_state == StEmit) && (r_out_row == 2'd3);
        io_bus.frame_done = w_out_hs && (r_out_row == 2'd3);
        io_bus.sat_count  = r_sat_count;
    end

    // Requantize the current row's elements in parallel; column 0 lands in the MSBs.
    always_comb begin
        logic [OUT_W:0] w_res;
        w_res     = '0;
        w_row     = '0;
        w_row_sat = '0;
        for (int c = 0; c < NumCols; c++) begin
            w_res = requant(r_elem[{r_req, 2'(c)}], r_shift);
            w_row[(NumCols - 1 - c) * OUT_W +: OUT_W] = w_res[OUT_W-1:0];
            w_row_sat = w_row_sat + {2'b00, w_res[OUT_W]};
        end
    end

    // Datapath: element capture, row buffering, saturation tally and output row pointer.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_req       <= '0;
            r_sat_acc   <= '0;
            r_sat_count <= '0;
            r_out_row   <= '0;
            for (int i = 0; i < NumElem; i++) r_elem[i] <= '0;
            for (int i = 0; i < NumRows; i++) r_row_buf[i] <= '0;
        end else begin
            unique case (r_state)
                StCollect: begin
                    if (w_in_hs) begin
                        r_elem[{r_cnt, 1'b0}] <= io_bus.in_data[63:32];
                        r_elem[{r_cnt, 1'b1}] <= io_bus.in_data[31:0];
                        if (r_cnt == '0) r_shift <= io_bus.shift_amt;
                        if (r_cnt == LastBeat) begin
                            r_cnt     <= '0;
                            r_req     <= '0;
                            r_sat_acc <= '0;
                        end else begin
                            r_cnt <= r_cnt + CntW'(1);
                        end
                    end
                end
                StRequant: begin
                    r_row_buf[r_req] <= w_row;
                    r_req            <= r_req + 2'd1;
                    r_sat_acc        <= r_sat_acc + {2'b00, w_row_sat};
                    if (r_req == 2'd3) r_sat_count <= r_sat_acc + {2'b00, w_row_sat};
                end
                StEmit: begin
                    // Wraps back to row 0 on the final handshake.
                    if (w_out_hs) r_out_row <= r_out_row + 2'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/result_requant.md
Name: result_requant

Overview:
- Downstream stage of the 4x4 systolic matrix-multiply top.
- Consumes the 512-bit result matrix (16 signed 32-bit accumulators) streamed as eight 64-bit beats over a valid/ready handshake.
- Requantizes each element to signed int8 using a programmable rounding right shift with saturation.
- Emits the matrix row by row as packed 32-bit words to the next consumer, which is a writeback or next-layer feeder.

Parameters:
NUM_BEATS, 8, input beats per matrix (16 elements x 32 bit / 64 bit)
ACC_W, 32, width of one accumulator element
OUT_W, 8, width of one requantized element

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
in_data  input  64  result beat; element 2k in [63:32], element 2k+1 in [31:0]; beat 0 carries y[0][0], y[0][1]
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a beat
shift_amt  input  5  right-shift amount, 0..31; sampled on acceptance of beat 0
out_data  output  32  one result row; col0 in [31:24] ... col3 in [7:0]
out_row  output  2  row index of out_data
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts row
out_last  output  1  high with row 3
frame_done  output  1  one-cycle pulse on the row-3 handshake
sat_count  output  5  number of saturated elements in the last completed frame (0..16)

Behaviour:
- Reset (reset==0 at posedge):
  - state=COLLECT; beat counter=0.
  - in_ready=1, out_valid=0, out_last=0, frame_done=0, out_row=0, out_data=0, sat_count=0.
  - Element buffer and row buffer are cleared.
  - Reset asserted mid-frame discards all partial data; no output is produced for that frame.
- States: COLLECT -> REQUANT -> EMIT -> COLLECT.
- COLLECT:
  - in_ready=1.
  - On each in_valid&&in_ready, store both elements at indices 2*cnt and 2*cnt+1, then increment cnt.
  - On the beat-0 handshake, latch shift_amt into shift_q.
  - On the handshake with cnt==7: cnt<=0 and go to REQUANT.
  - in_valid low inserts idle cycles with no effect.
- REQUANT:
  - 4 cycles, in_ready=0.
  - Cycle r (r=0..3) processes the 4 elements of row r in parallel and registers the packed row into row buffer r.
  - Per element x:
    - If shift_q==0: v = x.
    - Otherwise: v = (x + 2^(shift_q-1)) >>> shift_q, computed in 33-bit signed so the rounding add cannot overflow. This is round-half-up toward +inf.
    - If v>127, output 0x7F. If v<-128, output 0x80. Either case counts as one saturation.
  - The saturation counter is cleared on entry to REQUANT and accumulates across the 4 cycles.
  - After cycle 3: sat_count <= total and go to EMIT. sat_count holds until the next frame's REQUANT completes.
- EMIT:
  - out_valid=1, out_data=row_buf[out_row], out_last=(out_row==3).
  - out_data, out_row and out_last are stable while out_valid&&!out_ready.
  - On each handshake, out_row increments.
  - On the row-3 handshake: frame_done=1 for that cycle, out_row<=0, go to COLLECT. in_ready=1 from the next cycle.
  - in_ready=0 throughout EMIT; there is no input/output overlap.
- Latency:
  - Beat-7 handshake at cycle t -> REQUANT at t+1..t+4 -> out_valid first high at t+5.
  - With out_ready held high, the last row handshake is at t+8 and in_ready=1 at t+9.
- Inputs presented while in_ready=0 are ignored; the upstream block holds them.

Test Plan:
1. All 16 elements 0x00000100, shift_amt=4, out_ready=1 -> four rows 0x10101010, out_row 0..3, out_last only on row 3, frame_done at t+8, sat_count=0.
2. Rounding and sign, with shift_amt=1:
   - Elements 3, -5, 1, -1 in row 0 -> out_data=0x02FE0100.
   - Check: (3+1)>>1=2, (-5+1)>>>1=-2, (1+1)>>1=1, (-1+1)>>>1=0.
3. Saturation, with shift_amt=0:
   - Row 0 = 0x00010000, 0x80000000, 127, -128 -> out_data=0x7F807F80.
   - Remaining rows 0 -> sat_count=2.
4. Backpressure:
   - out_ready low for 5 cycles on row 1 -> out_data/out_row stay at row 1, in_ready stays 0.
   - Rows continue in order after release, with no loss or duplication.
5. Input gaps and sampling:
   - in_valid toggles 1/0 across the 8 beats.
   - shift_amt changes to 0 after beat 0 while 2 was latched -> shift 2 applied to all elements.
6. Reset mid-frame:
   - Drop reset after beat 4, then send a fresh 8-beat frame with all elements 0x7F and shift 0.
   - Required: output only 0x7F7F7F7F rows, sat_count=0, no rows emitted from the aborted frame.
